// File: rtl/z80_bank_bridge_if.sv
// Pin bundle between the Z80 side and the 68k bus side of the bank bridge.
// The bridge uses the slave modport; the surrounding logic uses the master modport.
interface z80_bank_bridge_if;
  logic [15:0] ZA;
  logic [7:0]  ZD_i;
  logic [7:0]  ZD_o;
  logic        ZD_d;
  logic        ZMREQ;
  logic        ZRD;
  logic        ZWR;
  logic        WAIT_pull;
  logic        BR_pull;
  logic        BG;
  logic        BGACK_pull;
  logic [22:0] VA_o;
  logic [15:0] VD_i;
  logic [15:0] VD_o;
  logic        VA_d;
  logic        VD_d;
  logic        AS_o;
  logic        UDS_o;
  logic        LDS_o;
  logic        RW_o;
  logic        CTL_d;
  logic        DTACK;

  modport slave (
    input  ZA, ZD_i, ZMREQ, ZRD, ZWR, BG, VD_i, DTACK,
    output ZD_o, ZD_d, WAIT_pull, BR_pull, BGACK_pull, VA_o, VD_o,
           VA_d, VD_d, AS_o, UDS_o, LDS_o, RW_o, CTL_d
  );

  modport master (
    output ZA, ZD_i, ZMREQ, ZRD, ZWR, BG, VD_i, DTACK,
    input  ZD_o, ZD_d, WAIT_pull, BR_pull, BGACK_pull, VA_o, VD_o,
           VA_d, VD_d, AS_o, UDS_o, LDS_o, RW_o, CTL_d
  );
endinterface

// File: rtl/z80_bank_bridge.sv
// Z80 0x8000-0xFFFF window into 68k space through a 9-bit serial bank register.
// Each window access requests the 68k bus, runs one strobed cycle, and stalls the Z80 with WAIT.
module z80_bank_bridge #(
  parameter int unsigned BG_SYNC    = 2,
  parameter int unsigned AS_SETUP   = 1,
  parameter int unsigned DT_TIMEOUT = 0
) (
  input  logic              MCLK,
  input  logic              RESET,
  z80_bank_bridge_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_OWN, S_STRB, S_DTW, S_LATCH, S_REL, S_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] cnt_nx;
  logic [8:0]  bank_q, bank_d;
  logic        served_q, served_d;
  logic [23:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic        tmo_q, tmo_d;
  logic        wait_q, wait_d;
  logic        br_q, br_d;
  logic        bgack_q, bgack_d;
  logic [7:0]  zd_q, zd_d;
  logic        zd_off_q, zd_off_d;
  logic [22:0] va_q, va_d;
  logic [15:0] vd_q, vd_d;
  logic        va_off_q, va_off_d;
  logic        vd_off_q, vd_off_d;
  logic        ctl_off_q, ctl_off_d;
  logic        as_q, as_d;
  logic        uds_q, uds_d;
  logic        lds_q, lds_d;
  logic        rw_q, rw_d;
  logic        bank_hit, win_hit;

  assign bank_hit = ~bus.ZMREQ & ~bus.ZWR & (bus.ZA[15:8] == 8'h60) & ~served_q;
  assign win_hit  = ~bus.ZMREQ & bus.ZA[15] & (~bus.ZRD | ~bus.ZWR) & ~served_q
                    & (state_q == S_IDLE);
  assign cnt_nx   = 32'(cnt_q) + 32'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bank_d    = bank_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    tmo_d     = tmo_q;
    wait_d    = wait_q;
    br_d      = br_q;
    bgack_d   = bgack_q;
    zd_d      = zd_q;
    zd_off_d  = zd_off_q;
    va_d      = va_q;
    vd_d      = vd_q;
    va_off_d  = va_off_q;
    vd_off_d  = vd_off_q;
    ctl_off_d = ctl_off_q;
    as_d      = as_q;
    uds_d     = uds_q;
    lds_d     = lds_q;
    rw_d      = rw_q;

    // served blocks repeat handling until the Z80 ends this MREQ, even mid-cycle
    served_d = bus.ZMREQ ? 1'b0 : (served_q | bank_hit | win_hit);
    if (bank_hit) bank_d = {bus.ZD_i[0], bank_q[8:1]};

    case (state_q)
      S_IDLE: begin
        if (win_hit) begin
          state_d = S_REQ;
          wait_d  = 1'b1;
          br_d    = 1'b1;
          addr_d  = {bank_q, bus.ZA[14:0]};
          wr_d    = ~bus.ZWR;
          cnt_d   = '0;
        end
      end
      S_REQ: begin
        if (!bus.BG) begin
          if (cnt_nx >= BG_SYNC) begin
            state_d   = S_OWN;
            cnt_d     = '0;
            br_d      = 1'b0;
            bgack_d   = 1'b1;
            va_off_d  = 1'b0;
            ctl_off_d = 1'b0;
            vd_off_d  = ~wr_q;
            va_d      = addr_q[23:1];
            rw_d      = ~wr_q;
            if (wr_q) vd_d = {bus.ZD_i, bus.ZD_i};
          end else begin
            cnt_d = cnt_nx[15:0];
          end
        end else begin
          cnt_d = '0;
        end
      end
      S_OWN: begin
        if (cnt_nx >= AS_SETUP) begin
          state_d = S_STRB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_nx[15:0];
        end
      end
      S_STRB: begin
        state_d = S_DTW;
        as_d    = 1'b0;
        uds_d   = addr_q[0];
        lds_d   = ~addr_q[0];
        cnt_d   = '0;
        tmo_d   = 1'b0;
      end
      S_DTW: begin
        if (!bus.DTACK) begin
          state_d = S_LATCH;
        end else if ((DT_TIMEOUT != 0) && (cnt_nx >= DT_TIMEOUT)) begin
          state_d = S_LATCH;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_nx[15:0];
        end
      end
      S_LATCH: begin
        if (!wr_q) begin
          if (tmo_q)          zd_d = 8'hFF;
          else if (addr_q[0]) zd_d = bus.VD_i[7:0];
          else                zd_d = bus.VD_i[15:8];
        end
        as_d    = 1'b1;
        uds_d   = 1'b1;
        lds_d   = 1'b1;
        state_d = S_REL;
      end
      S_REL: begin
        va_off_d  = 1'b1;
        vd_off_d  = 1'b1;
        ctl_off_d = 1'b1;
        rw_d      = 1'b1;
        bgack_d   = 1'b0;
        wait_d    = 1'b0;
        zd_off_d  = wr_q;
        state_d   = S_HOLD;
      end
      S_HOLD: begin
        if (bus.ZMREQ) begin
          zd_off_d = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bank_q    <= '0;
      served_q  <= 1'b0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      tmo_q     <= 1'b0;
      wait_q    <= 1'b0;
      br_q      <= 1'b0;
      bgack_q   <= 1'b0;
      zd_q      <= '0;
      zd_off_q  <= 1'b1;
      va_q      <= '0;
      vd_q      <= '0;
      va_off_q  <= 1'b1;
      vd_off_q  <= 1'b1;
      ctl_off_q <= 1'b1;
      as_q      <= 1'b1;
      uds_q     <= 1'b1;
      lds_q     <= 1'b1;
      rw_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bank_q    <= bank_d;
      served_q  <= served_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      tmo_q     <= tmo_d;
      wait_q    <= wait_d;
      br_q      <= br_d;
      bgack_q   <= bgack_d;
      zd_q      <= zd_d;
      zd_off_q  <= zd_off_d;
      va_q      <= va_d;
      vd_q      <= vd_d;
      va_off_q  <= va_off_d;
      vd_off_q  <= vd_off_d;
      ctl_off_q <= ctl_off_d;
      as_q      <= as_d;
      uds_q     <= uds_d;
      lds_q     <= lds_d;
      rw_q      <= rw_d;
    end
  end

  assign bus.ZD_o       = zd_q;
  assign bus.ZD_d       = zd_off_q;
  assign bus.WAIT_pull  = wait_q;
  assign bus.BR_pull    = br_q;
  assign bus.BGACK_pull = bgack_q;
  assign bus.VA_o       = va_q;
  assign bus.VD_o       = vd_q;
  assign bus.VA_d       = va_off_q;
  assign bus.VD_d       = vd_off_q;
  assign bus.CTL_d      = ctl_off_q;
  assign bus.AS_o       = as_q;
  assign bus.UDS_o      = uds_q;
  assign bus.LDS_o      = lds_q;
  assign bus.RW_o       = rw_q;

endmodule

// File: tb/tb_z80_bank_bridge.sv
// Directed bench for z80_bank_bridge: per-cycle vector table for a full window read,
// plus hand-written sequences for write, BG glitch, DTACK timeout and reset mid-cycle.
module tb_z80_bank_bridge;

  logic MCLK = 1'b0;
  logic RESET;
  always #5 MCLK = ~MCLK;

  z80_bank_bridge_if zb ();

  z80_bank_bridge #(
    .BG_SYNC    (2),
    .AS_SETUP   (1),
    .DT_TIMEOUT (8)
  ) dut (
    .MCLK  (MCLK),
    .RESET (RESET),
    .bus   (zb)
  );

  // ctl = {ZMREQ, ZRD, ZWR, BG, DTACK}
  // exp = {WAIT, BR, BGACK, AS, UDS, LDS, RW, VA_d, CTL_d, ZD_d, VA_o[22:0], ZD_o[7:0]}
  typedef struct {
    logic [4:0]  ctl;
    logic [15:0] za;
    logic [15:0] vd;
    logic [40:0] exp;
  } vec_t;

  vec_t        tv [12];
  logic [40:0] cur;
  int          nchk = 0;
  int          nerr = 0;

  assign cur = {zb.WAIT_pull, zb.BR_pull, zb.BGACK_pull, zb.AS_o, zb.UDS_o, zb.LDS_o,
                zb.RW_o, zb.VA_d, zb.CTL_d, zb.ZD_d, zb.VA_o, zb.ZD_o};

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic drive(input logic [4:0] c, input logic [15:0] za, input logic [15:0] vd);
    zb.ZMREQ = c[4];
    zb.ZRD   = c[3];
    zb.ZWR   = c[2];
    zb.BG    = c[1];
    zb.DTACK = c[0];
    zb.ZA    = za;
    zb.VD_i  = vd;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  initial begin
    // Window read of 0x8001 with bank 9'h155: BG low after 2 cycles, DTACK on the 3rd DTW cycle
    tv[0]  = '{5'b00111, 16'h8001, 16'h0000, {10'b1101111111, 23'h000000, 8'h00}};
    tv[1]  = '{5'b00111, 16'h8001, 16'h0000, {10'b1101111111, 23'h000000, 8'h00}};
    tv[2]  = '{5'b00101, 16'h8001, 16'h0000, {10'b1101111111, 23'h000000, 8'h00}};
    tv[3]  = '{5'b00101, 16'h8001, 16'h0000, {10'b1011111001, 23'h554000, 8'h00}};
    tv[4]  = '{5'b00101, 16'h8001, 16'h0000, {10'b1011111001, 23'h554000, 8'h00}};
    tv[5]  = '{5'b00101, 16'h8001, 16'h0000, {10'b1010101001, 23'h554000, 8'h00}};
    tv[6]  = '{5'b00101, 16'h8001, 16'h0000, {10'b1010101001, 23'h554000, 8'h00}};
    tv[7]  = '{5'b00101, 16'h8001, 16'h0000, {10'b1010101001, 23'h554000, 8'h00}};
    tv[8]  = '{5'b00100, 16'h8001, 16'hA55A, {10'b1010101001, 23'h554000, 8'h00}};
    tv[9]  = '{5'b00100, 16'h8001, 16'hA55A, {10'b1011111001, 23'h554000, 8'h5A}};
    tv[10] = '{5'b00111, 16'h8001, 16'h0000, {10'b0001111110, 23'h554000, 8'h5A}};
    tv[11] = '{5'b11111, 16'h8001, 16'h0000, {10'b0001111111, 23'h554000, 8'h5A}};

    // Reset state
    drive(5'b11111, 16'h0000, 16'h0000);
    zb.ZD_i = 8'h00;
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    tick();
    chk("reset_outs", 64'(cur), 64'({10'b0001111111, 23'h000000, 8'h00}));
    chk("reset_vd_d", 64'(zb.VD_d), 64'd1);

    // Bank shift: nine writes to 0x6000, first one held low for extra cycles
    for (int i = 0; i < 9; i++) begin
      zb.ZD_i = {7'b0, ~i[0]};
      drive(5'b01011, 16'h6000, 16'h0000);
      tick();
      if (i == 0) begin
        tick();
        tick();
        chk("bank_no_wait", 64'(zb.WAIT_pull), 64'd0);
      end
      drive(5'b11111, 16'h6000, 16'h0000);
      tick();
    end

    // Table-driven window read
    for (int i = 0; i < 12; i++) begin
      drive(tv[i].ctl, tv[i].za, tv[i].vd);
      tick();
      chk($sformatf("rd_vec%0d", i), 64'(cur), 64'(tv[i].exp));
    end

    // Window write 0x8000 = 8'h3C, BG already low
    zb.ZD_i = 8'h3C;
    drive(5'b01001, 16'h8000, 16'h0000);
    tick();
    chk("wr_wait_br", 64'({zb.WAIT_pull, zb.BR_pull}), 64'(2'b11));
    tick();
    tick();
    chk("wr_bgack", 64'(zb.BGACK_pull), 64'd1);
    chk("wr_vd", 64'(zb.VD_o), 64'h3C3C);
    chk("wr_rw_vdd", 64'({zb.RW_o, zb.VD_d}), 64'(2'b00));
    chk("wr_va", 64'(zb.VA_o), 64'h554000);
    tick();
    tick();
    chk("wr_strobes", 64'({zb.AS_o, zb.UDS_o, zb.LDS_o}), 64'(3'b001));
    drive(5'b01000, 16'h8000, 16'h0000);
    tick();
    tick();
    chk("wr_as_rise", 64'({zb.AS_o, zb.BGACK_pull}), 64'(2'b11));
    tick();
    chk("wr_release", 64'({zb.BGACK_pull, zb.WAIT_pull, zb.ZD_d}), 64'(3'b001));
    drive(5'b11111, 16'h0000, 16'h0000);
    tick();

    // BG glitch, then MREQ rising mid-cycle does not abort
    zb.ZD_i = 8'h00;
    drive(5'b00111, 16'h8000, 16'h0000);
    tick();
    drive(5'b00101, 16'h8000, 16'h0000);
    tick();
    drive(5'b00111, 16'h8000, 16'h0000);
    tick();
    chk("bg_glitch_a", 64'({zb.BR_pull, zb.BGACK_pull}), 64'(2'b10));
    drive(5'b00101, 16'h8000, 16'h0000);
    tick();
    chk("bg_glitch_b", 64'({zb.BR_pull, zb.BGACK_pull}), 64'(2'b10));
    tick();
    chk("bg_glitch_own", 64'({zb.BR_pull, zb.BGACK_pull}), 64'(2'b01));
    tick();
    tick();
    chk("bg_strobes", 64'({zb.AS_o, zb.UDS_o, zb.LDS_o}), 64'(3'b001));
    drive(5'b11101, 16'h8000, 16'h1234);
    tick();
    chk("mreq_noabort", 64'({zb.WAIT_pull, zb.AS_o}), 64'(2'b10));
    drive(5'b11100, 16'h8000, 16'h1234);
    tick();
    tick();
    chk("rd_even_data", 64'(zb.ZD_o), 64'h12);
    tick();
    chk("rd_even_rel", 64'({zb.WAIT_pull, zb.ZD_d}), 64'(2'b00));
    tick();
    chk("rd_even_idle", 64'(zb.ZD_d), 64'd1);
    drive(5'b11111, 16'h0000, 16'h0000);
    tick();
    tick();
    chk("no_retrigger", 64'({zb.WAIT_pull, zb.BR_pull}), 64'(2'b00));

    // DTACK timeout on a read
    drive(5'b00101, 16'h8001, 16'h0000);
    for (int i = 0; i < 5; i++) tick();
    chk("tmo_as_low", 64'(zb.AS_o), 64'd0);
    begin
      int n;
      n = 0;
      while (zb.AS_o !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      chk("tmo_cycles", 64'(n), 64'd9);
    end
    chk("tmo_data", 64'(zb.ZD_o), 64'hFF);
    tick();
    chk("tmo_release", 64'({zb.WAIT_pull, zb.BR_pull, zb.BGACK_pull, zb.VA_d, zb.VD_d,
                           zb.CTL_d, zb.AS_o, zb.UDS_o, zb.LDS_o}), 64'(9'b000111111));
    drive(5'b11111, 16'h0000, 16'h0000);
    tick();

    // Reset while waiting for DTACK
    drive(5'b00101, 16'h8001, 16'h0000);
    for (int i = 0; i < 5; i++) tick();
    chk("rst_in_dtw", 64'({zb.AS_o, zb.WAIT_pull}), 64'(2'b01));
    RESET = 1'b1;
    drive(5'b11111, 16'h0000, 16'h0000);
    tick();
    chk("rst_mid_outs", 64'(cur), 64'({10'b0001111111, 23'h000000, 8'h00}));
    chk("rst_mid_vd_d", 64'(zb.VD_d), 64'd1);
    RESET = 1'b0;
    drive(5'b00101, 16'h8002, 16'h0000);
    tick();
    tick();
    tick();
    chk("rst_bank_zero", 64'({zb.BGACK_pull, zb.VA_o}), 64'({1'b1, 23'h000001}));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
